// File: rtl/uart_frame_sched_pkg.sv
// Shared types and constants for the telemetry frame scheduler.
// Holds the FSM state encoding, default header bytes and frame byte indices.
package uart_frame_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [7:0] HDR0_DEF = 8'h55;
    localparam logic [7:0] HDR1_DEF = 8'hAA;

    localparam logic [5:0] IDX_HDR0 = 6'd0;
    localparam logic [5:0] IDX_HDR1 = 6'd1;
    localparam logic [5:0] IDX_SEQ  = 6'd2;
    localparam logic [5:0] IDX_PAY  = 6'd3;

    // Index of the checksum byte: frame length is 2*n+4.
    function automatic logic [5:0] last_idx(input int n);
        return 6'(2 * n + 3);
    endfunction

endpackage

// File: rtl/uart_frame_sched_frame_byte_sel.sv
// frame_byte_sel: combinational mux picking the frame byte at byte_idx_i.
// Ports: byte_idx_i, seq_i, snap_i (channel snapshot), chk_i -> byte_o.
module frame_byte_sel
    import uart_frame_sched_pkg::*;
#(
    parameter int         NUM_CH = 6,
    parameter logic [7:0] HDR0   = HDR0_DEF,
    parameter logic [7:0] HDR1   = HDR1_DEF
) (
    input  logic [5:0]            byte_idx_i,
    input  logic [7:0]            seq_i,
    input  logic [NUM_CH*16-1:0]  snap_i,
    input  logic [7:0]            chk_i,
    output logic [7:0]            byte_o
);

    localparam logic [5:0] LAST = last_idx(NUM_CH);

    logic [5:0]  pay_idx;
    logic [15:0] word;

    always_comb begin
        pay_idx = byte_idx_i - IDX_PAY;
        word    = '0;
        byte_o  = '0;
        // Two bytes per channel: even offset is the MSB.
        for (int k = 0; k < NUM_CH; k++) begin
            if (pay_idx[5:1] == 5'(k)) begin
                word = snap_i[k*16 +: 16];
            end
        end
        unique case (1'b1)
            (byte_idx_i == IDX_HDR0): byte_o = HDR0;
            (byte_idx_i == IDX_HDR1): byte_o = HDR1;
            (byte_idx_i == IDX_SEQ):  byte_o = seq_i;
            (byte_idx_i == LAST):     byte_o = chk_i;
            default:                  byte_o = pay_idx[0] ? word[7:0] : word[15:8];
        endcase
    end

endmodule

// File: rtl/uart_frame_sched.sv
// uart_frame_sched: snapshots NUM_CH channel words per strobe and streams
// HDR0 HDR1 SEQ payload CHK to uart_tx over a valid/ready byte port.
// Ports: clk, rst_n, enable, sample_stb, ch_data in; tx_data, tx_data_valid,
// busy, frame_done, overrun_cnt out; tx_data_ready in.
module uart_frame_sched
    import uart_frame_sched_pkg::*;
#(
    parameter int         NUM_CH = 6,
    parameter logic [7:0] HDR0   = HDR0_DEF,
    parameter logic [7:0] HDR1   = HDR1_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  sample_stb,
    input  logic [NUM_CH*16-1:0]  ch_data,
    output logic [7:0]            tx_data,
    output logic                  tx_data_valid,
    input  logic                  tx_data_ready,
    output logic                  busy,
    output logic                  frame_done,
    output logic [7:0]            overrun_cnt
);

    localparam logic [5:0] LAST = last_idx(NUM_CH);

    state_e                 state_q;
    logic [NUM_CH*16-1:0]   snap_q;
    logic [5:0]             idx_q;
    logic [7:0]             chk_q;
    logic [7:0]             seq_q;
    logic [7:0]             ovr_q;
    logic                   valid_q;
    logic                   busy_q;
    logic                   done_q;
    logic [7:0]             byte_d;
    logic                   stb_en;

    assign stb_en = sample_stb && enable;

    frame_byte_sel #(
        .NUM_CH (NUM_CH),
        .HDR0   (HDR0),
        .HDR1   (HDR1)
    ) u_sel (
        .byte_idx_i (idx_q),
        .seq_i      (seq_q),
        .snap_i     (snap_q),
        .chk_i      (chk_q),
        .byte_o     (byte_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            snap_q  <= '0;
            idx_q   <= '0;
            chk_q   <= '0;
            seq_q   <= '0;
            ovr_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Any accepted strobe outside IDLE is dropped and counted.
            if (stb_en && state_q != S_IDLE && ovr_q != 8'hFF) begin
                ovr_q <= ovr_q + 8'd1;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (stb_en) begin
                        snap_q  <= ch_data;
                        idx_q   <= '0;
                        chk_q   <= '0;
                        state_q <= S_SEND;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (tx_data_ready) begin
                        // Sum covers SEQ and payload, not headers or CHK.
                        if (idx_q >= IDX_SEQ && idx_q < LAST) begin
                            chk_q <= chk_q + byte_d;
                        end
                        if (idx_q == LAST) begin
                            state_q <= S_DONE;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 6'd1;
                        end
                    end
                end
                S_DONE: begin
                    seq_q   <= seq_q + 8'd1;
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_data       = valid_q ? byte_d : 8'h00;
    assign tx_data_valid = valid_q;
    assign busy          = busy_q;
    assign frame_done    = done_q;
    assign overrun_cnt   = ovr_q;

endmodule

// File: tb/tb_uart_frame_sched.sv
// Scoreboard bench for uart_frame_sched: expected frame bytes are queued
// when a strobe is driven and popped as the DUT hands bytes to uart_tx.
module tb_uart_frame_sched;

    localparam int NCH = 6;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            enable = 1'b0;
    logic            sample_stb = 1'b0;
    logic [NCH*16-1:0] ch_data = '0;
    logic [7:0]      tx_data;
    logic            tx_data_valid;
    logic            tx_data_ready = 1'b0;
    logic            busy;
    logic            frame_done;
    logic [7:0]      overrun_cnt;

    int   n_checks = 0;
    int   n_errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_seq = 8'h00;
    int   rdy_mode = 0;
    int   done_cnt = 0;
    int   byte_pos = 0;
    logic [7:0] last_seq = 8'h00;
    logic [7:0] last_chk = 8'h00;

    uart_frame_sched #(.NUM_CH(NCH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .sample_stb    (sample_stb),
        .ch_data       (ch_data),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready),
        .busy          (busy),
        .frame_done    (frame_done),
        .overrun_cnt   (overrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Ready pattern: 0 always, 1 one cycle in ten, 2 never.
    initial begin
        int cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (rdy_mode)
                0: tx_data_ready = 1'b1;
                1: tx_data_ready = (cyc % 10 == 0);
                default: tx_data_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops a byte on each cycle that ends in an accept.
    initial begin
        logic       stall_prev = 1'b0;
        logic [7:0] data_prev = '0;
        logic       fd_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
                fd_prev = 1'b0;
                byte_pos = 0;
            end else begin
                if (stall_prev) begin
                    chk("hold_valid", tx_data_valid, 1);
                    chk("hold_data", tx_data, data_prev);
                end
                if (tx_data_valid && tx_data_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_underflow", exp_q.size(), 1);
                    end else begin
                        chk("byte", tx_data, exp_q.pop_front());
                    end
                    if (byte_pos == 2) last_seq = tx_data;
                    if (byte_pos == 2 * NCH + 3) last_chk = tx_data;
                    byte_pos++;
                end
                if (frame_done) begin
                    chk("done_1cyc", fd_prev, 0);
                    done_cnt++;
                    byte_pos = 0;
                end
                stall_prev = tx_data_valid && !tx_data_ready;
                data_prev = tx_data;
                fd_prev = frame_done;
            end
        end
    end

    task automatic push_frame(input logic [NCH*16-1:0] d);
        logic [7:0] s;
        logic [7:0] b;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        exp_q.push_back(exp_seq);
        s = exp_seq;
        for (int k = 0; k < NCH; k++) begin
            b = d[k*16+8 +: 8];
            exp_q.push_back(b);
            s = s + b;
            b = d[k*16 +: 8];
            exp_q.push_back(b);
            s = s + b;
        end
        exp_q.push_back(s);
        exp_seq = exp_seq + 8'd1;
    endtask

    // Starts a frame from IDLE and checks one-cycle latency to HDR0.
    task automatic start_frame(input logic [NCH*16-1:0] d);
        @(posedge clk);
        #1;
        enable = 1'b1;
        ch_data = d;
        sample_stb = 1'b1;
        push_frame(d);
        @(posedge clk);
        #1;
        sample_stb = 1'b0;
        chk("lat_valid", tx_data_valid, 1);
        chk("lat_hdr0", tx_data, 8'h55);
        ch_data = {$urandom, $urandom, $urandom};
    endtask

    task automatic pulse_stb();
        @(posedge clk);
        #1;
        ch_data = {$urandom, $urandom, $urandom};
        sample_stb = 1'b1;
        @(posedge clk);
        #1;
        sample_stb = 1'b0;
    endtask

    // Returns at negedge+1 of the DONE cycle, or on budget expiry.
    task automatic wait_done(input int budget);
        int target;
        target = done_cnt + 1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt >= target) break;
        end
        chk("frame_done", done_cnt, target);
        chk("sb_drained", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        exp_seq = 8'h00;
        sample_stb = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    function automatic logic [NCH*16-1:0] ramp();
        logic [NCH*16-1:0] d;
        for (int k = 0; k < NCH; k++) begin
            d[k*16 +: 16] = {8'(2 * k + 1), 8'(2 * k + 2)};
        end
        return d;
    endfunction

    initial begin
        int n;
        // Reset state
        #12;
        chk("rst_data", tx_data, 0);
        chk("rst_valid", tx_data_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_ovr", overrun_cnt, 0);
        do_reset();
        n = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx_data_valid) n++;
        end
        chk("idle_valid", n, 0);

        // Ramp frame, full rate
        rdy_mode = 0;
        start_frame(ramp());
        chk("busy", busy, 1);
        wait_done(100);
        chk("ramp_chk", last_chk, 8'h4E);
        chk("ramp_seq", last_seq, 8'h00);
        start_frame(ramp());
        wait_done(100);
        chk("seq_next", last_seq, 8'h01);

        // Backpressure
        rdy_mode = 1;
        start_frame({$urandom, $urandom, $urandom});
        wait_done(400);

        // Overrun: two strobes mid-frame, one during DONE
        rdy_mode = 1;
        start_frame({$urandom, $urandom, $urandom});
        repeat (20) @(posedge clk);
        pulse_stb();
        repeat (30) @(posedge clk);
        pulse_stb();
        wait_done(400);
        sample_stb = 1'b1;
        @(posedge clk);
        #1;
        sample_stb = 1'b0;
        repeat (5) @(negedge clk);
        chk("ovr3", overrun_cnt, 3);
        chk("no_frame", tx_data_valid, 0);

        // Saturation
        rdy_mode = 2;
        start_frame({$urandom, $urandom, $urandom});
        sample_stb = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        sample_stb = 1'b0;
        chk("ovr_sat", overrun_cnt, 255);
        rdy_mode = 0;
        wait_done(100);

        // Sequence wrap over 257 frames
        do_reset();
        rdy_mode = 0;
        for (int f = 1; f <= 257; f++) begin
            start_frame({$urandom, $urandom, $urandom});
            wait_done(100);
            if (f == 256) chk("seq256", last_seq, 8'hFF);
            if (f == 257) chk("seq257", last_seq, 8'h00);
        end

        // Reset after byte 5 accepted
        rdy_mode = 0;
        start_frame(ramp());
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (byte_pos >= 5) break;
        end
        chk("reach_b5", byte_pos, 5);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        exp_seq = 8'h00;
        #1;
        chk("async_valid", tx_data_valid, 0);
        chk("async_busy", busy, 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        start_frame(ramp());
        wait_done(100);
        chk("rst_seq", last_seq, 8'h00);

        // enable low: strobe ignored
        @(posedge clk);
        #1;
        enable = 1'b0;
        sample_stb = 1'b1;
        @(posedge clk);
        #1;
        sample_stb = 1'b0;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_data_valid) n++;
        end
        chk("en0_frame", n, 0);
        chk("en0_ovr", overrun_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
